// File: rtl/fft_stage_sequencer.sv
// Sequences one radix-2 FFT pass: issues one butterfly per cycle per stage, drains between stages.
// Latency: first issue one cycle after start is accepted; writeback tags trail issue by PIPE_LAT cycles.
// Backpressure: stall blocks issue only in RUN (counters hold); DRAIN and the writeback delay line ignore it.
// Optional FFT_PERF_CNT_EN adds perfCycles, a saturating count of busy cycles in the last pass.
module fft_stage_sequencer #(
  parameter int NUM_STAGES     = 10,
  parameter int BFLY_PER_STAGE = 512,
  parameter int PIPE_LAT       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic [4:0] stageCount,
  output logic [8:0] cycleCount,
  output logic       bflyValid,
  output logic       wbValid,
  output logic [4:0] wbStage,
  output logic [8:0] wbCycle,
  output logic       busy,
  output logic       done
`ifdef FFT_PERF_CNT_EN
  ,
  output logic [15:0] perfCycles
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Drain counter counts 0 .. PIPE_LAT-1; at least one bit wide.
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt;
  logic            accept;
  logic            last_issue;
  logic            last_drain;
  logic            last_stage;

  logic [PIPE_LAT-1:0] dly_vld;
  logic [4:0]          dly_stage [PIPE_LAT];
  logic [8:0]          dly_cycle [PIPE_LAT];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt  = state;
    bflyValid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    last_issue = 1'b0;
    last_drain = 1'b0;
    last_stage = (stageCount == 5'(NUM_STAGES - 1));
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        bflyValid = !stall;
        if (!stall && (cycleCount == 9'(BFLY_PER_STAGE - 1))) begin
          last_issue = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DW'(PIPE_LAT - 1)) begin
          last_drain = 1'b1;
          state_nxt  = last_stage ? DONE : RUN;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage/cycle/drain counters; cleared in DONE so IDLE always presents zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      stageCount <= '0;
      cycleCount <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          stageCount <= '0;
          cycleCount <= '0;
          drain_cnt  <= '0;
        end
        RUN: begin
          drain_cnt <= '0;
          if (bflyValid) begin
            if (last_issue) cycleCount <= '0;
            else            cycleCount <= cycleCount + 1'b1;
          end
        end
        DRAIN: begin
          if (last_drain) begin
            drain_cnt <= '0;
            if (!last_stage) stageCount <= stageCount + 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          stageCount <= '0;
          cycleCount <= '0;
        end
        default: ;
      endcase
    end
  end

  // Free-running writeback tag delay line, PIPE_LAT deep.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dly_vld[i]   <= 1'b0;
        dly_stage[i] <= '0;
        dly_cycle[i] <= '0;
      end
    end else begin
      dly_vld[0]   <= bflyValid;
      dly_stage[0] <= stageCount;
      dly_cycle[0] <= cycleCount;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dly_vld[i]   <= dly_vld[i-1];
        dly_stage[i] <= dly_stage[i-1];
        dly_cycle[i] <= dly_cycle[i-1];
      end
    end
  end

  assign wbValid = dly_vld[PIPE_LAT-1];
  assign wbStage = dly_stage[PIPE_LAT-1];
  assign wbCycle = dly_cycle[PIPE_LAT-1];

`ifdef FFT_PERF_CNT_EN
  // Busy-cycle counter: restarts when a pass is accepted, saturates, holds after done.
  always_ff @(posedge clk) begin
    if (rst)                              perfCycles <= '0;
    else if (accept)                      perfCycles <= '0;
    else if (busy && perfCycles != 16'hFFFF) perfCycles <= perfCycles + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: stimulus pushes expected issue,
// writeback and done events (with cycle stamps); a negedge monitor pops and compares.
module tb_fft_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic [4:0] stageCount;
  logic [8:0] cycleCount;
  logic       bflyValid;
  logic       wbValid;
  logic [4:0] wbStage;
  logic [8:0] wbCycle;
  logic       busy;
  logic       done;
`ifdef FFT_PERF_CNT_EN
  logic [15:0] perfCycles;
`endif

  fft_stage_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .stageCount (stageCount),
    .cycleCount (cycleCount),
    .bflyValid  (bflyValid),
    .wbValid    (wbValid),
    .wbStage    (wbStage),
    .wbCycle    (wbCycle),
    .busy       (busy),
    .done       (done)
`ifdef FFT_PERF_CNT_EN
    ,
    .perfCycles (perfCycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int c;
    int t;
  } ev_t;

  ev_t iq[$];
  ev_t wq[$];
  int  dq_t[$];
`ifdef FFT_PERF_CNT_EN
  int  dq_p[$];
`endif

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  mon_en = 1'b0;
  localparam int BIG = 32'h3FFF_FFFF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int x);
    while (cyc < x) tick();
  endtask

  // Expected events for a pass whose start is sampled in cycle T. Stall cycles
  // [st0, st0+slen) postpone the next issue; events after cycle 'stop' are dropped.
  task automatic gen(input int T, input int st0, input int slen, input int stop);
    int t;
    t = T + 1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 512; c++) begin
        while (t >= st0 && t < st0 + slen) t++;
        if (t <= stop)     iq.push_back('{k, c, t});
        if (t + 4 <= stop) wq.push_back('{k, c, t + 4});
        t++;
      end
      t += 4;
    end
    if (t <= stop) begin
      dq_t.push_back(t);
`ifdef FFT_PERF_CNT_EN
      dq_p.push_back(t - T - 1);
`endif
    end
  endtask

  ev_t ie, we;
  int  dt;

  // Monitor: every presented issue / writeback / done must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bflyValid !== 1'b0) begin
        if (iq.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          ie = iq.pop_front();
          chk("issue_stage", 32'(stageCount), ie.s);
          chk("issue_cycle", 32'(cycleCount), ie.c);
          chk("issue_time", cyc, ie.t);
        end
      end
      if (wbValid !== 1'b0) begin
        if (wq.size() == 0) chk("unexpected_wb", 1, 0);
        else begin
          we = wq.pop_front();
          chk("wb_stage", 32'(wbStage), we.s);
          chk("wb_cycle", 32'(wbCycle), we.c);
          chk("wb_time", cyc, we.t);
        end
      end
      if (done !== 1'b0) begin
        if (dq_t.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dt = dq_t.pop_front();
          chk("done_time", cyc, dt);
          chk("done_busy", 32'(busy), 0);
`ifdef FFT_PERF_CNT_EN
          chk("perf_cycles", 32'(perfCycles), dq_p.pop_front());
`endif
        end
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stage"}, 32'(stageCount), 0);
    chk({tag, "_cycle"}, 32'(cycleCount), 0);
    chk({tag, "_bvld"},  32'(bflyValid), 0);
    chk({tag, "_wbvld"}, 32'(wbValid), 0);
    chk({tag, "_wbstg"}, 32'(wbStage), 0);
    chk({tag, "_wbcyc"}, 32'(wbCycle), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
`ifdef FFT_PERF_CNT_EN
    chk({tag, "_perf"},  32'(perfCycles), 0);
`endif
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, iq.size() + wq.size() + dq_t.size(), 0);
  endtask

  int T, T2, R;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_idle_outputs("reset");
    mon_en = 1'b1;

    // Clean pass: done at T+5161, stage 3 first issue at T+1549.
    tick();
    start = 1'b1; T = cyc; gen(T, 0, 0, BIG);
    tick(); start = 1'b0;
    wait_to(T + 5166);
    chk_empty("clean_pass_drained");

    // Three stall cycles at stage 0, cycleCount 100: done slips to T+5164.
    start = 1'b1; T = cyc; gen(T, T + 101, 3, BIG);
    tick(); start = 1'b0;
    wait_to(T + 101); stall = 1'b1;
    wait_to(T + 102); chk("stall_hold_cycle", 32'(cycleCount), 100);
    wait_to(T + 104); stall = 1'b0;
    wait_to(T + 5168);
    chk_empty("stall_pass_drained");

    // Starts while busy, stall during DRAIN, start held across DONE into IDLE.
    start = 1'b1; T = cyc; gen(T, 0, 0, BIG);
    tick(); start = 1'b0;
    wait_to(T + 514); stall = 1'b1;
    wait_to(T + 515); start = 1'b1;
    tick(); start = 1'b0; stall = 1'b0;
    wait_to(T + 1083); start = 1'b1;
    tick(); start = 1'b0;
    wait_to(T + 5161); start = 1'b1;
    tick();
    T2 = cyc; gen(T2, 0, 0, BIG);
    tick(); start = 1'b0;
    wait_to(T2 + 5166);
    chk_empty("back_to_back_drained");

    // Reset mid-pass at stage 5, cycleCount 200.
    start = 1'b1; T = cyc; R = T + 2781; gen(T, 0, 0, R);
    tick(); start = 1'b0;
    wait_to(R);
    chk("pre_reset_stage", 32'(stageCount), 5);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_idle_outputs("abort");
    repeat (8) tick();
    chk("abort_no_busy", 32'(busy), 0);
    chk_empty("abort_drained");

    // Full clean pass after the abort.
    start = 1'b1; T = cyc; gen(T, 0, 0, BIG);
    tick(); start = 1'b0;
    wait_to(T + 5166);
    chk_empty("post_abort_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
